reg_xfer_ctrl: RTL and testbench
================================

Name: reg_xfer_ctrl

Overview:
- Register-transfer sequencer sitting directly upstream of the CPU register file.
- Accepts one move/exchange/load-immediate/read command at a time and drives the register file's single address/data/load port as a timed sequence.
- Register file timing it drives:
  - Read: `rf_load=0` with `rf_addr` in cycle N → `rf_rdata` valid in cycle N+1.
  - Write: `rf_load=1` writes `rf_data` at the clock edge ending the cycle.
- Provides the register "moving value exchange" path without a second register-file port.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 16, register-file address bus width
- IDX_W, 4, register index width (16 registers)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command (high only in IDLE, low while rst_n=0)
- cmd_op  in  2  00 MOV dst←src, 01 XCHG src↔dst, 10 LDI dst←imm, 11 READ src
- cmd_src  in  IDX_W  source register index
- cmd_dst  in  IDX_W  destination register index
- cmd_imm  in  DATA_W  immediate for LDI
- rf_addr  out  ADDR_W  register-file address, zero-extended index
- rf_data  out  DATA_W  register-file write data
- rf_load  out  1  register-file write enable (1 write, 0 read)
- rf_rdata  in  DATA_W  register-file registered read output
- rsp_valid  out  1  READ result available
- rsp_ready  in  1  READ result consumed
- rsp_data  out  DATA_W  READ result
- done  out  1  one-cycle pulse on command completion

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous, active-low.
- Reset values: state=IDLE, `rf_addr`=0, `rf_data`=0, `rf_load`=0, `rsp_valid`=0, `rsp_data`=0, `done`=0, internal `tmp_a`/`tmp_b`=0.
- Reset gating: `rf_load` is gated combinationally with `rst_n`. A cycle with `rst_n=0` never writes, even mid-sequence.
- Command accept: on `cmd_valid & cmd_ready` in IDLE, latch op/src/dst/imm. Later changes on `cmd_*` are ignored until the next IDLE.
- Port decode: `rf_*` are decoded from the current state and the latched fields (Moore).
  - `rf_addr = {zeros, idx}`.
  - In non-write states: `rf_load=0` and `rf_data=0`.
- States and per-cycle actions:
  - IDLE: `rf_addr=0`, `rf_load=0`. Next state on accept: LDI→WR_B; otherwise → RD_A.
  - RD_A: addr=src, load=0. → RD_B.
  - RD_B: addr=dst, load=0; `tmp_a` ← `rf_rdata` (= old mem[src]). READ→RSP; MOV/XCHG→WR_B.
  - WR_B: addr=dst, load=1.
    - `rf_data` = imm (LDI) or `tmp_a` (MOV/XCHG).
    - `tmp_b` ← `rf_rdata` (= old mem[dst]).
    - XCHG→WR_A; else → IDLE with `done`=1 in the following cycle.
  - WR_A: addr=src, load=1, `rf_data=tmp_b`. → IDLE, `done`=1 next cycle.
  - RSP: `rsp_valid=1`, `rsp_data=tmp_a` (held stable). On `rsp_ready` → IDLE, `done`=1 next cycle, `rsp_valid` drops the same edge.
- Latency, accept to `done` pulse: LDI 2, MOV 4, XCHG 5, READ ≥4 (plus `rsp_ready` stall cycles).
- `done` is high exactly one cycle and coincides with IDLE, so `cmd_ready=1` in the same cycle. Back-to-back commands: the next accept may occur in the `done` cycle.
- src==dst cases:
  - XCHG: two writes of the original value; register unchanged.
  - MOV: one write of the same value.
- Index width: upper `rf_addr` bits are always 0, with no out-of-range handling since IDX_W covers all registers.
- Reset mid-operation: sequence aborted, no further writes, no `done`, no `rsp_valid`; IDLE on the next cycle.

Test Plan:
- Reset: `rst_n=0` for 2 cycles while `cmd_valid=1`, op=LDI → `rf_load` never 1, `cmd_ready=0`; after release, `cmd_ready=1`, all outputs 0.
- LDI: dst=5, imm=0x1234 → WR_B cycle shows `rf_addr=0x0005`, `rf_load=1`, `rf_data=0x1234`; `done` 2 cycles after accept; model reg5=0x1234.
- MOV and READ: preload r1=1000, r2=100.
  - MOV src=1, dst=2 → single write at addr 2 with data 1000, `done` at +4; r1 unchanged.
  - Then READ src=2 → `rsp_data=1000`.
- XCHG: r0=10, r7=5000; XCHG src=0, dst=7 → writes addr7←10 then addr0←5000 in consecutive cycles; `done` at +5; r0=5000, r7=10.
- READ backpressure: r4=10000, `rsp_ready` held low 3 cycles → `rsp_valid`/`rsp_data=10000` stable throughout; `cmd_ready=0`; one `done` after the `rsp_ready` edge.
- Reset mid-XCHG: assert `rst_n=0` during WR_B → that write suppressed, no WR_A, no `done`; both registers keep their original values.

Source files
------------

// File: rtl/reg_xfer_ctrl.sv
// Register-transfer sequencer: turns MOV/XCHG/LDI/READ commands into timed accesses on
// the register file's single address/data/load port, including swaps through temporaries.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RD_A  | read request for src
// RD_B  | read request for dst, capture old src value into tmp_a
// WR_B  | write dst (imm or tmp_a), capture old dst value into tmp_b
// WR_A  | write src with tmp_b (exchange only)
// RSP   | hold READ result until consumed
module reg_xfer_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [IDX_W-1:0]  cmd_src,
    input  logic [IDX_W-1:0]  cmd_dst,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              rf_load,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR_B = 3'd3,
        WR_A = 3'd4,
        RSP  = 3'd5
    } state_t;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_XCHG = 2'b01;
    localparam logic [1:0] OP_LDI  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    state_t              state;
    logic [1:0]          op_q;
    logic [IDX_W-1:0]    src_q;
    logic [IDX_W-1:0]    dst_q;
    logic [DATA_W-1:0]   imm_q;
    logic [DATA_W-1:0]   tmp_a;
    logic [DATA_W-1:0]   tmp_b;
    logic                load_raw;

    assign cmd_ready = (state == IDLE) && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= OP_MOV;
            src_q     <= '0;
            dst_q     <= '0;
            imm_q     <= '0;
            tmp_a     <= '0;
            tmp_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q  <= cmd_op;
                        src_q <= cmd_src;
                        dst_q <= cmd_dst;
                        imm_q <= cmd_imm;
                        state <= (cmd_op == OP_LDI) ? WR_B : RD_A;
                    end
                end
                RD_A: state <= RD_B;
                RD_B: begin
                    tmp_a <= rf_rdata;
                    if (op_q == OP_READ) begin
                        rsp_data  <= rf_rdata;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end else begin
                        state <= WR_B;
                    end
                end
                WR_B: begin
                    // rf_rdata here is the dst value read in RD_B, before this cycle's write lands
                    tmp_b <= rf_rdata;
                    if (op_q == OP_XCHG) begin
                        state <= WR_A;
                    end else begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                WR_A: begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                        done      <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rf_addr  = '0;
        rf_data  = '0;
        load_raw = 1'b0;
        case (state)
            RD_A: rf_addr = ADDR_W'(src_q);
            RD_B: rf_addr = ADDR_W'(dst_q);
            WR_B: begin
                rf_addr  = ADDR_W'(dst_q);
                rf_data  = (op_q == OP_LDI) ? imm_q : tmp_a;
                load_raw = 1'b1;
            end
            WR_A: begin
                rf_addr  = ADDR_W'(src_q);
                rf_data  = tmp_b;
                load_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // A reset cycle must never write, even if the state register still says WR_*
    assign rf_load = load_raw && rst_n;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Directed bench for reg_xfer_ctrl with a behavioural register file on the rf_* port.
module tb_reg_xfer_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int IDX_W  = 4;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_XCHG = 2'b01;
    localparam logic [1:0] OP_LDI  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [IDX_W-1:0]  cmd_src;
    logic [IDX_W-1:0]  cmd_dst;
    logic [DATA_W-1:0] cmd_imm;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              rf_load;
    logic [DATA_W-1:0] rf_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_xfer_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_imm   (cmd_imm),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .rf_load   (rf_load),
        .rf_rdata  (rf_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .done      (done)
    );

    // Register file: registered read, write at the edge ending a load cycle
    logic [DATA_W-1:0] mem [16];
    int                wr_count = 0;

    always @(posedge clk) begin
        if (rf_load === 1'b1) begin
            mem[rf_addr[3:0]] <= rf_data;
            wr_count <= wr_count + 1;
        end
        rf_rdata <= mem[rf_addr[3:0]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a command in the current IDLE cycle; returns one cycle after the accept edge
    task automatic send_cmd(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                            input logic [15:0] imm);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_imm   = imm;
        step();
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_src   = ~src;
        cmd_dst   = ~dst;
        cmd_imm   = ~imm;
    endtask

    task automatic wait_done(input string tag, output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic ldi(input logic [3:0] idx, input logic [15:0] val);
        int lat;
        send_cmd(OP_LDI, 4'd0, idx, val);
        wait_done("ldi_done", lat);
        check("ldi_latency", 32'(lat), 32'd2);
    endtask

    initial begin
        int lat;
        int wr0;

        // Reset held with an LDI pending on the command port
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_LDI;
        cmd_src   = 4'd0;
        cmd_dst   = 4'd3;
        cmd_imm   = 16'hFFFF;
        rsp_ready = 1'b1;
        repeat (2) begin
            step();
            check("rst_rf_load", 32'(rf_load), 32'd0);
            check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        #1;
        check("rst_cmd_ready_hi", 32'(cmd_ready), 32'd1);
        check("rst_rf_addr", 32'(rf_addr), 32'd0);
        check("rst_rf_data", 32'(rf_data), 32'd0);
        check("rst_rf_load_rel", 32'(rf_load), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_no_writes", 32'(wr_count), 32'd0);
        step();

        // LDI r5 <- 0x1234
        send_cmd(OP_LDI, 4'd0, 4'd5, 16'h1234);
        check("ldi_wr_addr", 32'(rf_addr), 32'h0005);
        check("ldi_wr_load", 32'(rf_load), 32'd1);
        check("ldi_wr_data", 32'(rf_data), 32'h1234);
        check("ldi_done_early", 32'(done), 32'd0);
        step();
        check("ldi_done_p2", 32'(done), 32'd1);
        check("ldi_ready_p2", 32'(cmd_ready), 32'd1);
        check("ldi_mem5", 32'(mem[5]), 32'h1234);
        step();
        check("ldi_done_1cyc", 32'(done), 32'd0);

        // MOV r2 <- r1, r1=1000 r2=100
        ldi(4'd1, 16'd1000);
        ldi(4'd2, 16'd100);
        wr0 = wr_count;
        send_cmd(OP_MOV, 4'd1, 4'd2, 16'h0000);
        check("mov_rda_addr", 32'(rf_addr), 32'h0001);
        check("mov_rda_load", 32'(rf_load), 32'd0);
        step();
        check("mov_rdb_addr", 32'(rf_addr), 32'h0002);
        check("mov_rdb_load", 32'(rf_load), 32'd0);
        step();
        check("mov_wr_addr", 32'(rf_addr), 32'h0002);
        check("mov_wr_load", 32'(rf_load), 32'd1);
        check("mov_wr_data", 32'(rf_data), 32'd1000);
        step();
        check("mov_done_p4", 32'(done), 32'd1);
        check("mov_one_write", 32'(wr_count - wr0), 32'd1);
        check("mov_r2", 32'(mem[2]), 32'd1000);
        check("mov_r1", 32'(mem[1]), 32'd1000);

        // READ r2, accepted back-to-back in the done cycle
        send_cmd(OP_READ, 4'd2, 4'd6, 16'h0000);
        step();
        step();
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rsp_data", 32'(rsp_data), 32'd1000);
        check("rd_no_load", 32'(rf_load), 32'd0);
        step();
        check("rd_done_p4", 32'(done), 32'd1);
        check("rd_rsp_drop", 32'(rsp_valid), 32'd0);

        // XCHG r0 <-> r7, r0=10 r7=5000
        ldi(4'd0, 16'd10);
        ldi(4'd7, 16'd5000);
        send_cmd(OP_XCHG, 4'd0, 4'd7, 16'h0000);
        step();
        step();
        check("xchg_wb_addr", 32'(rf_addr), 32'h0007);
        check("xchg_wb_load", 32'(rf_load), 32'd1);
        check("xchg_wb_data", 32'(rf_data), 32'd10);
        step();
        check("xchg_wa_addr", 32'(rf_addr), 32'h0000);
        check("xchg_wa_load", 32'(rf_load), 32'd1);
        check("xchg_wa_data", 32'(rf_data), 32'd5000);
        check("xchg_done_early", 32'(done), 32'd0);
        step();
        check("xchg_done_p5", 32'(done), 32'd1);
        check("xchg_r0", 32'(mem[0]), 32'd5000);
        check("xchg_r7", 32'(mem[7]), 32'd10);

        // XCHG with src==dst leaves the register unchanged
        send_cmd(OP_XCHG, 4'd5, 4'd5, 16'h0000);
        wait_done("xchg_same_done", lat);
        check("xchg_same_lat", 32'(lat), 32'd5);
        check("xchg_same_r5", 32'(mem[5]), 32'h1234);

        // READ r4 with rsp_ready low for 3 cycles
        ldi(4'd4, 16'd10000);
        rsp_ready = 1'b0;
        send_cmd(OP_READ, 4'd4, 4'd9, 16'h0000);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", 32'(rsp_data), 32'd10000);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_done", 32'(done), 32'd0);
            if (i == 2) rsp_ready = 1'b1;
            step();
        end
        check("bp_done_after", 32'(done), 32'd1);
        check("bp_rsp_drop", 32'(rsp_valid), 32'd0);
        step();
        check("bp_done_once", 32'(done), 32'd0);

        // Reset during WR_B of XCHG r0 <-> r7 (r0=5000, r7=10)
        wr0 = wr_count;
        send_cmd(OP_XCHG, 4'd0, 4'd7, 16'h0000);
        step();
        step();
        check("mrst_in_wrb", 32'(rf_load), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_load_gated", 32'(rf_load), 32'd0);
        step();
        check("mrst_ready_lo", 32'(cmd_ready), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_addr", 32'(rf_addr), 32'd0);
        rst_n = 1'b1;
        #1;
        check("mrst_ready_hi", 32'(cmd_ready), 32'd1);
        repeat (3) begin
            step();
            check("mrst_no_done", 32'(done), 32'd0);
            check("mrst_no_load", 32'(rf_load), 32'd0);
            check("mrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check("mrst_no_writes", 32'(wr_count - wr0), 32'd0);
        check("mrst_r0", 32'(mem[0]), 32'd5000);
        check("mrst_r7", 32'(mem[7]), 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
